// File: rtl/button_event.sv
// Turns a debounced button level into one-cycle press/release/long-press/auto-repeat events.
// The release and repeat pulses carry an _evt suffix because both bare names are reserved words.
module button_event #(
    parameter int unsigned LONG_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 12_500_000,
    parameter int unsigned CNT_W         = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic level_in,
    input  logic rep_en,
    output logic press,
    output logic release_evt,
    output logic long_press,
    output logic repeat_evt,
    output logic held
);

    typedef enum logic [1:0] {StIdle, StDown, StRepeat} state_e;

    localparam logic [CNT_W-1:0] LongLast   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] RepeatLast = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             level_q;
    logic             press_d, release_d, long_d, repeat_d;
    logic             rise, fall;

    assign rise = level_in & ~level_q;
    assign fall = ~level_in & level_q;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (rise) begin
                    press_d = 1'b1;
                    count_d = '0;
                    state_d = StDown;
                end
            end
            StDown: begin
                // A fall wins over terminal count, so a short hold never reports long_press.
                if (fall) begin
                    release_d = 1'b1;
                    count_d   = '0;
                    state_d   = StIdle;
                end else if (count_q == LongLast) begin
                    long_d  = 1'b1;
                    count_d = '0;
                    state_d = StRepeat;
                end else begin
                    count_d = count_q + CntOne;
                end
            end
            StRepeat: begin
                if (fall) begin
                    release_d = 1'b1;
                    count_d   = '0;
                    state_d   = StIdle;
                end else if (!rep_en) begin
                    count_d = '0;
                end else if (count_q == RepeatLast) begin
                    repeat_d = 1'b1;
                    count_d  = '0;
                end else begin
                    count_d = count_q + CntOne;
                end
            end
            default: begin
                state_d = StIdle;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            count_q     <= '0;
            level_q     <= 1'b0;
            press       <= 1'b0;
            release_evt <= 1'b0;
            long_press  <= 1'b0;
            repeat_evt  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            level_q     <= level_in;
            press       <= press_d;
            release_evt <= release_d;
            long_press  <= long_d;
            repeat_evt  <= repeat_d;
        end
    end

    assign held = (state_q != StIdle);

endmodule

// File: doc/button_event.md
# button_event

Converts the clean, slow-sampled level from the `debounce` stage into single-cycle game-input events: press, release, long-press and auto-repeat. It sits between each debounced push-button and the tic-tac-toe control FSM, which consumes pulses only and never raw levels. All outputs are registered, and each event asserts for exactly one `clk` cycle.

## Interface
Parameters:
- `LONG_CYCLES`, default 50_000_000: cycles the button must be held before `long_press` fires (1 s at 50 MHz). Must be ≥ 2.
- `REPEAT_CYCLES`, default 12_500_000: period of `repeat` pulses after `long_press`. Must be ≥ 2.
- `CNT_W`, default 26: hold-counter width. 2^CNT_W must be ≥ max(`LONG_CYCLES`, `REPEAT_CYCLES`).

Ports:
- `clk`, input, 1: system clock; single clock domain.
- `rst`, input, 1: asynchronous, active-low reset.
- `level_in`, input, 1: debounced button level, synchronous to `clk`; 1 = pressed.
- `rep_en`, input, 1: enables auto-repeat pulses.
- `press`, output, 1: one-cycle pulse on a rising button level.
- `release`, output, 1: one-cycle pulse on a falling button level.
- `long_press`, output, 1: one-cycle pulse after the button has been held for `LONG_CYCLES`.
- `repeat`, output, 1: one-cycle pulse every `REPEAT_CYCLES` after `long_press` while held and `rep_en` = 1.
- `held`, output, 1: high while the FSM is not IDLE.

## Operation
- `level_q` registers `level_in` each cycle. Rise = `level_in` & ~`level_q`; fall = ~`level_in` & `level_q`.
- FSM states: IDLE, DOWN, REPEAT. `count` is `CNT_W` bits wide.
- IDLE, on rise: `press` <= 1, `count` <= 0, go to DOWN.
- DOWN:
  - On fall: `release` <= 1, go to IDLE.
  - Else if `count` == `LONG_CYCLES`-1: `long_press` <= 1, `count` <= 0, go to REPEAT.
  - Else `count` <= `count`+1.
- REPEAT:
  - On fall: `release` <= 1, go to IDLE.
  - Else if `rep_en` = 0: `count` <= 0 (held cleared, no pulses).
  - Else if `count` == `REPEAT_CYCLES`-1: `repeat` <= 1, `count` <= 0.
  - Else `count` <= `count`+1.
- Priority: fall beats terminal count in the same cycle. Only `release` fires, with no `long_press` or `repeat`.
- `rep_en` toggling mid-REPEAT: deassert clears `count`. Reassert starts a full `REPEAT_CYCLES` period from 0.
- `count` never wraps. It is always cleared at terminal count or on state entry.
- `held` = (state != IDLE), registered with the state.
- At most one of `press`, `release`, `long_press`, `repeat` is high in any cycle.

## Timing
- Reset (`rst` = 0, asynchronous): state IDLE, `count` = 0, `level_q` = 0. Every output is 0.
- If `level_in` = 1 when `rst` deasserts, the first clock edge detects a rise and `press` fires in the following cycle. A button held through reset counts as a fresh press.
- Latencies, taking rise sampled at edge k as the reference:
  - `press` and `held` are high after edge k; `press` lasts one cycle.
  - `long_press` is high after edge k+`LONG_CYCLES`.
  - `repeat` is high after edge k+`LONG_CYCLES`+n·`REPEAT_CYCLES`, n ≥ 1, with `rep_en` steady 1.
- Fall sampled at edge m: `release` is high after edge m and `held` drops after edge m.
- Reset asserted mid-hold: outputs clear immediately. No `release` is generated.

## Test plan
Bench parameters: `LONG_CYCLES`=8, `REPEAT_CYCLES`=4, `CNT_W`=4.
- Reset with `level_in`=0, then idle 20 cycles -> all outputs stay 0 and `held`=0.
- `level_in` rises at edge k and falls at edge k+3 -> `press` one cycle after k, `release` one cycle after k+3, no `long_press`, `held` high for 3 cycles.
- Hold 20 cycles with `rep_en`=1 -> `press`@k, `long_press`@k+8, `repeat`@k+12 and k+16, then `release` on fall.
- Same hold with `rep_en`=0 -> `long_press`@k+8, zero `repeat` pulses. Raise `rep_en` at k+14 -> first `repeat` at k+18.
- Fall sampled on the exact edge where `count`=`LONG_CYCLES`-1 -> `release` only, `long_press` never asserts, state IDLE.
- `level_in`=1 through reset, then deassert `rst` -> `press` one cycle after the first edge. Reassert `rst` mid-hold -> all outputs 0 asynchronously and no `release`.
